// File: rtl/shift_rows_pipe_pkg.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe_pkg
//
// Purpose: shared AES definitions for the pipelined ShiftRows stage. Holds
// the 128-bit state type, the permutation direction enum and the helpers
// that map (row, column) to a byte position inside the state vector.
//
// State layout: byte k occupies bits [127-8k -: 8]. Byte k is row (k % 4),
// column (k / 4), so a column is four consecutive bytes, most significant
// byte first.
//
// Contents:
//   state_t    - logic [127:0] AES state
//   sr_dir_t   - SR_FWD (ShiftRows) / SR_INV (InvShiftRows)
//   byte_idx   - (row, col) -> byte number k
//   byte_msb   - (row, col) -> most significant bit of that byte
//   src_col    - column a byte is fetched from for a given direction
// ---------------------------------------------------------------------------
package shift_rows_pipe_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int BYTE_W   = 8;
  localparam int STATE_W  = NUM_ROWS * NUM_COLS * BYTE_W;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic {
    SR_FWD = 1'b0,
    SR_INV = 1'b1
  } sr_dir_t;

  // Byte number of the cell at (row, col); columns are stored contiguously.
  function automatic int byte_idx(input int row, input int col);
    return NUM_ROWS * col + row;
  endfunction

  // Top bit of the cell at (row, col) inside a state_t.
  function automatic int byte_msb(input int row, input int col);
    return STATE_W - 1 - BYTE_W * byte_idx(row, col);
  endfunction

  // Source column for output cell (row, col).
  // Forward rotates row r left by r bytes, inverse rotates it right by r.
  // The +NUM_COLS keeps the inverse operand non-negative before the modulo.
  function automatic int src_col(input int row, input int col, input bit inverse);
    if (inverse) begin
      return (col - row + NUM_COLS) % NUM_COLS;
    end
    return (col + row) % NUM_COLS;
  endfunction

endpackage

// File: rtl/shift_rows_pipe_if.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe_if
//
// Purpose: bundles the upstream and downstream valid/ready streams of the
// ShiftRows pipeline plus the busy indicator into one interface.
//
// Signals:
//   in_valid   upstream transaction valid
//   in_ready   pipeline accepts the upstream transaction this cycle
//   in_inverse 0 = ShiftRows, 1 = InvShiftRows
//   in_state   128-bit AES state to permute
//   in_tag     opaque sideband carried alongside the state
//   in_bypass  (SHIFTROWS_BYPASS_EN only) pass the state through unpermuted
//   out_valid  downstream transaction valid
//   out_ready  downstream accepts
//   out_state  permuted state
//   out_tag    tag of the transaction at the output
//   busy       at least one pipeline stage holds a valid transaction
//
// Modports:
//   master - the environment: drives in_* and out_ready
//   slave  - the pipeline: drives in_ready, out_*, busy
//
// Optional feature macro: SHIFTROWS_BYPASS_EN adds in_bypass.
// ---------------------------------------------------------------------------
interface shift_rows_pipe_if
  import shift_rows_pipe_pkg::*;
#(
  parameter int TAG_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_inverse;
  state_t           in_state;
  logic [TAG_W-1:0] in_tag;
`ifdef SHIFTROWS_BYPASS_EN
  logic             in_bypass;
`endif
  logic             out_valid;
  logic             out_ready;
  state_t           out_state;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid,
    output in_inverse,
    output in_state,
    output in_tag,
`ifdef SHIFTROWS_BYPASS_EN
    output in_bypass,
`endif
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_state,
    input  out_tag,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_inverse,
    input  in_state,
    input  in_tag,
`ifdef SHIFTROWS_BYPASS_EN
    input  in_bypass,
`endif
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_state,
    output out_tag,
    output busy
  );

endinterface

// File: rtl/shift_rows_pipe_perm.sv
// ---------------------------------------------------------------------------
// shift_rows_perm
//
// Purpose: purely combinational ShiftRows / InvShiftRows byte permutation.
// Both permutations are pure wiring, so both are built and a 3-way mux
// picks the result.
//
// Ports:
//   state_in   input  state_t   state to permute
//   dir        input  sr_dir_t  SR_FWD or SR_INV
//   bypass     input  1         (SHIFTROWS_BYPASS_EN only) identity select
//   state_out  output state_t   permuted state
//
// Optional feature macro: SHIFTROWS_BYPASS_EN adds the bypass input; when
// set the direction is ignored and the state passes through unchanged.
// ---------------------------------------------------------------------------
module shift_rows_perm
  import shift_rows_pipe_pkg::*;
(
  input  state_t  state_in,
  input  sr_dir_t dir,
`ifdef SHIFTROWS_BYPASS_EN
  input  logic    bypass,
`endif
  output state_t  state_out
);

  state_t fwd_state;
  state_t inv_state;
  logic   apply_perm;

  // Every output cell is a fixed copy of one input cell, so the permutation
  // is elaborated into constant-index wiring. Row 0 maps onto itself.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
      localparam int DST_MSB = byte_msb(r, c);
      localparam int FWD_MSB = byte_msb(r, src_col(r, c, 1'b0));
      localparam int INV_MSB = byte_msb(r, src_col(r, c, 1'b1));

      assign fwd_state[DST_MSB -: BYTE_W] = state_in[FWD_MSB -: BYTE_W];
      assign inv_state[DST_MSB -: BYTE_W] = state_in[INV_MSB -: BYTE_W];
    end
  end

`ifdef SHIFTROWS_BYPASS_EN
  assign apply_perm = !bypass;
`else
  assign apply_perm = 1'b1;
`endif

  always_comb begin
    state_out = state_in;
    if (apply_perm) begin
      state_out = (dir == SR_INV) ? inv_state : fwd_state;
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
//
// Purpose: pipelined ShiftRows / InvShiftRows stage with a valid/ready
// handshake and a per-transaction direction bit. The permutation is applied
// combinationally to the incoming state and captured into stage 1; stages
// 2..STAGES are plain registers. Each stage carries valid, state and tag.
//
// Parameters:
//   STAGES  number of register stages, 1..4 (= latency in cycles)
//   TAG_W   width of the sideband tag, >= 1
//
// Ports:
//   clock    input  rising-edge clock
//   reset_n  input  synchronous active-low reset
//   bus      shift_rows_pipe_if.slave
//              in_valid/in_ready/in_inverse/in_state/in_tag (upstream)
//              out_valid/out_ready/out_state/out_tag (downstream), busy
//
// Optional feature macro: SHIFTROWS_BYPASS_EN enables bus.in_bypass, which
// selects the identity permutation for that transaction.
// ---------------------------------------------------------------------------
module shift_rows_pipe
  import shift_rows_pipe_pkg::*;
#(
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  shift_rows_pipe_if.slave  bus
);

  logic [STAGES:1]  v;
  state_t           st [1:STAGES];
  logic [TAG_W-1:0] tg [1:STAGES];

  logic             advance;
  sr_dir_t          dir;
  state_t           perm_state;

  // The whole pipe moves as one: it only stalls when the last stage holds
  // data that downstream refuses. Bubbles are deliberately not collapsed,
  // which keeps out_ready -> in_ready down to a single gate.
  assign advance = !v[STAGES] || bus.out_ready;

  assign dir = bus.in_inverse ? SR_INV : SR_FWD;

  shift_rows_perm u_perm (
    .state_in  (bus.in_state),
    .dir       (dir),
`ifdef SHIFTROWS_BYPASS_EN
    .bypass    (bus.in_bypass),
`endif
    .state_out (perm_state)
  );

  for (genvar g = 1; g <= STAGES; g++) begin : g_stage
    logic             v_d;
    state_t           st_d;
    logic [TAG_W-1:0] tg_d;
    logic             v_q;
    state_t           st_q;
    logic [TAG_W-1:0] tg_q;

    // Stage 1 captures the freshly permuted input; later stages just copy.
    if (g == 1) begin : g_first
      assign v_d  = bus.in_valid;
      assign st_d = perm_state;
      assign tg_d = bus.in_tag;
    end else begin : g_next
      assign v_d  = v[g-1];
      assign st_d = st[g-1];
      assign tg_d = tg[g-1];
    end

    // Reset clears payload as well as valid so the outputs read zero after
    // a flush instead of exposing stale data.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        v_q  <= 1'b0;
        st_q <= '0;
        tg_q <= '0;
      end else if (advance) begin
        v_q  <= v_d;
        st_q <= st_d;
        tg_q <= tg_d;
      end
    end

    assign v[g]  = v_q;
    assign st[g] = st_q;
    assign tg[g] = tg_q;
  end

  // No accepts are advertised while the pipe is being reset.
  assign bus.in_ready  = reset_n && advance;
  assign bus.out_valid = v[STAGES];
  assign bus.out_state = st[STAGES];
  assign bus.out_tag   = tg[STAGES];
  assign bus.busy      = |v;

endmodule
